// File: rtl/adc_snap_capture_ctrl.sv
// ADC snapshot capture controller: arm / trigger / burst write into snapshot BRAM plus a polled status word.
// Optional build macro SNAP_CIRC_EN enables pre-trigger circular capture with a programmable post-trigger count.
module adc_snap_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
`ifdef SNAP_CIRC_EN
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
`endif

  state_e              state_q, state_d;
  logic                arm_prev_q, stop_prev_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wrapped_q, wrapped_d;
  logic [ADDR_W-1:0]   bram_addr_q, addr_d;
  logic [DATA_W-1:0]   bram_data_q;
  logic                bram_we_q, we_d;
  logic [31:0]         status_q, status_d;
  logic                arm_edge_s, stop_edge_s, wr_s, trig_s, do_write_s;
`ifdef SNAP_CIRC_EN
  logic [ADDR_W-1:0]   post_q, post_d, post_load_s;
`endif

  assign arm_edge_s  = ctrl[0] & ~arm_prev_q;
  assign stop_edge_s = ctrl[3] & ~stop_prev_q;
  assign wr_s        = din_vld | ctrl[2];
  assign trig_s      = trig | ctrl[1];

`ifdef SNAP_CIRC_EN
  // Post-trigger length is clamped so the post-trigger data can never overwrite the trigger sample.
  function automatic logic [ADDR_W-1:0] post_clamp(input logic [15:0] p);
    logic [31:0] wide;
    logic [31:0] lim;
    wide = {16'd0, p};
    lim  = (32'd1 << ADDR_W) - 32'd1;
    if (wide > lim) begin
      post_clamp = lim[ADDR_W-1:0];
    end else begin
      post_clamp = wide[ADDR_W-1:0];
    end
  endfunction

  assign post_load_s = post_clamp(ctrl[31:16]);

  logic unused_ctrl_s;
  assign unused_ctrl_s = ^ctrl[15:4];
`else
  logic unused_ctrl_s;
  assign unused_ctrl_s = ^{ctrl[31:16], ctrl[15:4]};
`endif

  // Next-state, write decision and next status word.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    addr_d     = bram_addr_q;
    we_d       = 1'b0;
    do_write_s = 1'b0;
    status_d   = 32'd0;
`ifdef SNAP_CIRC_EN
    post_d     = post_q;
`endif

    if (arm_edge_s) begin
      // Arm has priority over everything, including a simultaneous stop edge.
      state_d   = S_ARMED;
      count_d   = '0;
      wrapped_d = 1'b0;
`ifdef SNAP_CIRC_EN
      post_d    = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stop_edge_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARMED: begin
          if (stop_edge_s) begin
            state_d = S_DONE;
          end else if (trig_s) begin
            do_write_s = 1'b1;
`ifdef SNAP_CIRC_EN
            post_d = post_load_s;
            if (post_load_s == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CAPTURE;
            end
`else
            state_d = S_CAPTURE;
`endif
          end else begin
`ifdef SNAP_CIRC_EN
            do_write_s = wr_s;
`else
            do_write_s = 1'b0;
`endif
          end
        end
        S_CAPTURE: begin
          if (stop_edge_s) begin
            state_d = S_DONE;
          end else if (wr_s) begin
            do_write_s = 1'b1;
`ifdef SNAP_CIRC_EN
            post_d = post_q - ADDR_ONE;
            if (post_q == ADDR_ONE) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CAPTURE;
            end
`else
            if (count_q == LAST_COUNT) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CAPTURE;
            end
`endif
          end else begin
            state_d = S_CAPTURE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (do_write_s) begin
      we_d   = 1'b1;
      addr_d = count_q[ADDR_W-1:0];
`ifdef SNAP_CIRC_EN
      // Count stays modulo depth so that in DONE it points at the oldest sample.
      count_d = {1'b0, count_q[ADDR_W-1:0] + ADDR_ONE};
      if (count_q[ADDR_W-1:0] == ADDR_LAST) begin
        wrapped_d = 1'b1;
      end else begin
        wrapped_d = wrapped_q;
      end
`else
      count_d = count_q + COUNT_ONE;
`endif
    end else begin
      we_d = 1'b0;
    end

    status_d[31]       = (state_d == S_DONE);
    status_d[30]       = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    status_d[29]       = wrapped_d;
    status_d[ADDR_W:0] = count_d;
  end

  // All state, edge-detect history and registered outputs.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= S_IDLE;
      // Track ctrl through reset so a level held high is not mistaken for a fresh edge.
      arm_prev_q  <= ctrl[0];
      stop_prev_q <= ctrl[3];
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
      status_q    <= 32'd0;
`ifdef SNAP_CIRC_EN
      post_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      arm_prev_q  <= ctrl[0];
      stop_prev_q <= ctrl[3];
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      bram_addr_q <= addr_d;
      bram_data_q <= din;
      bram_we_q   <= we_d;
      status_q    <= status_d;
`ifdef SNAP_CIRC_EN
      post_q      <= post_d;
`endif
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign bram_we   = bram_we_q;
  assign status    = status_q;

endmodule
